// File: rtl/axis_spi_pkg.sv
// Shared types and constants for the AXI-Stream SPI slave.
package axis_spi_pkg;

    typedef enum logic {S_IDLE, S_SHIFT} SPI_SLV_STATE_T;

    localparam int SPI_BITS = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one SPI pin, plus a history flop that yields
// single-cycle rise/fall strobes in the aclk domain.
module spi_sync_edge #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              hist_q, hist_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        hist_d = sync_q[STAGES-1];
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            sync_q <= {STAGES{INIT}};
            hist_q <= INIT;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/axis_spi_slave_top.sv
// SPI slave (CPOL=0, MSB first) bridging oversampled SPI pins to a pair of
// AXI-Stream byte channels: s_axis feeds MISO, MOSI bytes leave on m_axis.
module axis_spi_slave_top
    import axis_spi_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FILL_BYTE   = 8'hFF
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       SCK_I,
    output logic       SCK_O,
    output logic       SCK_T,
    input  logic       SS_I,
    output logic       SS_O,
    output logic       SS_T,
    input  logic       IO0_I,
    output logic       IO0_O,
    output logic       IO0_T,
    input  logic       IO1_I,
    output logic       IO1_O,
    output logic       IO1_T,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       rx_overrun,
    output logic       tx_underrun,
    output logic       frame_abort
);

    logic sck_level, sck_rise, sck_fall;
    logic ss_level, ss_rise, ss_fall;
    logic mosi_sync, mosi_rise, mosi_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sck (
        .aclk(aclk), .aresetn(aresetn), .din(SCK_I),
        .level(sck_level), .rise(sck_rise), .fall(sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_ss (
        .aclk(aclk), .aresetn(aresetn), .din(SS_I),
        .level(ss_level), .rise(ss_rise), .fall(ss_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_mosi (
        .aclk(aclk), .aresetn(aresetn), .din(IO0_I),
        .level(mosi_sync), .rise(mosi_rise), .fall(mosi_fall)
    );

    // The slave never drives SCK, SS or MOSI; SCK rising edges carry no action.
    logic unused_sigs;
    assign unused_sigs = ^{IO1_I, sck_level, sck_rise, ss_level, mosi_rise, mosi_fall};

    assign SCK_O = 1'b0;
    assign SCK_T = 1'b1;
    assign SS_O  = 1'b1;
    assign SS_T  = 1'b1;
    assign IO0_O = 1'b0;
    assign IO0_T = 1'b1;

    SPI_SLV_STATE_T      state_q, state_d;
    logic [7:0]          hold_q, hold_d;
    logic                hold_valid_q, hold_valid_d;
    logic                s_ready_q, s_ready_d;
    logic [SPI_BITS-1:0] tx_sh_q, tx_sh_d;
    logic [SPI_BITS-1:0] rx_sh_q, rx_sh_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic [7:0]          rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                rx_overrun_q, rx_overrun_d;
    logic                tx_underrun_q, tx_underrun_d;
    logic                frame_abort_q, frame_abort_d;
    logic                load;
    logic [SPI_BITS-1:0] rx_byte;

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        hold_valid_d  = hold_valid_q;
        tx_sh_d       = tx_sh_q;
        rx_sh_d       = rx_sh_q;
        bit_cnt_d     = bit_cnt_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        rx_overrun_d  = 1'b0;
        tx_underrun_d = 1'b0;
        frame_abort_d = 1'b0;
        load          = 1'b0;
        rx_byte       = {rx_sh_q[SPI_BITS-2:0], mosi_sync};

        if (rx_valid_q && m_axis_tready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                bit_cnt_d = 4'd0;
                if (ss_fall) begin
                    load    = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // SS release takes priority over a coincident SCK edge.
                if (ss_rise) begin
                    state_d   = S_IDLE;
                    rx_sh_d   = '0;
                    bit_cnt_d = 4'd0;
                    if (bit_cnt_q != 4'd0) begin
                        frame_abort_d = 1'b1;
                    end
                end else if (sck_fall) begin
                    rx_sh_d = rx_byte;
                    if (bit_cnt_q == 4'(SPI_BITS - 1)) begin
                        bit_cnt_d = 4'd0;
                        load      = 1'b1;
                        if (rx_valid_q && !m_axis_tready) begin
                            rx_overrun_d = 1'b1;
                        end else begin
                            rx_data_d  = rx_byte;
                            rx_valid_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        tx_sh_d   = {tx_sh_q[SPI_BITS-2:0], 1'b0};
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            if (hold_valid_q) begin
                tx_sh_d      = hold_q;
                hold_valid_d = 1'b0;
            end else begin
                tx_sh_d       = FILL_BYTE;
                tx_underrun_d = 1'b1;
            end
        end

        if (s_axis_tvalid && s_ready_q) begin
            hold_d       = s_axis_tdata;
            hold_valid_d = 1'b1;
        end

        s_ready_d = !hold_valid_d;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q       <= S_IDLE;
            hold_q        <= '0;
            hold_valid_q  <= 1'b0;
            s_ready_q     <= 1'b0;
            tx_sh_q       <= '0;
            rx_sh_q       <= '0;
            bit_cnt_q     <= 4'd0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_overrun_q  <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            hold_valid_q  <= hold_valid_d;
            s_ready_q     <= s_ready_d;
            tx_sh_q       <= tx_sh_d;
            rx_sh_q       <= rx_sh_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_overrun_q  <= rx_overrun_d;
            tx_underrun_q <= tx_underrun_d;
            frame_abort_q <= frame_abort_d;
        end
    end

    assign IO1_O         = tx_sh_q[SPI_BITS-1];
    assign IO1_T         = (state_q == S_IDLE);
    assign s_axis_tready = s_ready_q;
    assign m_axis_tdata  = rx_data_q;
    assign m_axis_tvalid = rx_valid_q;
    assign rx_overrun    = rx_overrun_q;
    assign tx_underrun   = tx_underrun_q;
    assign frame_abort   = frame_abort_q;

endmodule

// File: tb/tb_axis_spi_slave_top.sv
// Directed bench: drives the SPI pins as a CPOL=0 master at 8 aclk per SCK
// period and checks both stream channels and the status pulses.
module tb_axis_spi_slave_top;

    logic       aclk;
    logic       aresetn;
    logic       SCK_I, SCK_O, SCK_T;
    logic       SS_I, SS_O, SS_T;
    logic       IO0_I, IO0_O, IO0_T;
    logic       IO1_I, IO1_O, IO1_T;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid, s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid, m_axis_tready;
    logic       rx_overrun, tx_underrun, frame_abort;

    axis_spi_slave_top #(.SYNC_STAGES(2), .FILL_BYTE(8'hFF)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .SCK_I(SCK_I), .SCK_O(SCK_O), .SCK_T(SCK_T),
        .SS_I(SS_I), .SS_O(SS_O), .SS_T(SS_T),
        .IO0_I(IO0_I), .IO0_O(IO0_O), .IO0_T(IO0_T),
        .IO1_I(IO1_I), .IO1_O(IO1_O), .IO1_T(IO1_T),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .rx_overrun(rx_overrun), .tx_underrun(tx_underrun), .frame_abort(frame_abort)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] tx_buf[16];
    int         tx_n = 0;
    logic [7:0] rx_log[64];
    int         rx_n = 0;
    int         und_cnt = 0;
    int         ovr_cnt = 0;
    int         abt_cnt = 0;
    int         tready_low_cnt = 0;
    logic       watch_tready = 1'b0;
    logic [7:0] mo_bytes[4];
    logic [7:0] mi_bytes[4];

    // TX source: presents queued bytes in order, advancing after each accepted beat.
    initial begin
        int   idx;
        logic acc;
        idx = 0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 8'h00;
        forever begin
            @(negedge aclk);
            acc = s_axis_tvalid && s_axis_tready;
            @(posedge aclk);
            #1;
            if (acc) idx++;
            if (idx < tx_n) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = tx_buf[idx];
            end else begin
                s_axis_tvalid = 1'b0;
            end
        end
    end

    // Observer: logs RX beats and counts status pulses mid-cycle.
    initial begin
        forever begin
            @(negedge aclk);
            if (m_axis_tvalid && m_axis_tready && rx_n < 64) begin
                rx_log[rx_n] = m_axis_tdata;
                rx_n++;
            end
            if (tx_underrun) und_cnt++;
            if (rx_overrun) ovr_cnt++;
            if (frame_abort) abt_cnt++;
            if (watch_tready && !s_axis_tready) tready_low_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_buf[tx_n] = b;
        tx_n++;
    endtask

    task automatic ss_low(input logic first_bit);
        IO0_I = first_bit;
        SS_I  = 1'b0;
        tick(6);
    endtask

    task automatic ss_high();
        SS_I = 1'b1;
        tick(8);
    endtask

    task automatic sck_bit(input logic nxt, output logic miso);
        SCK_I = 1'b1;
        tick(4);
        miso  = IO1_O;
        SCK_I = 1'b0;
        tick(2);
        IO0_I = nxt;
        tick(2);
    endtask

    task automatic xfer_byte(input logic [7:0] mo, input logic nxt_first, output logic [7:0] mi);
        logic b;
        logic nxt;
        for (int i = 7; i >= 0; i--) begin
            if (i > 0) nxt = mo[3'(i - 1)];
            else       nxt = nxt_first;
            sck_bit(nxt, b);
            mi[3'(i)] = b;
        end
    endtask

    task automatic run_frame(input int n);
        logic [7:0] mi;
        logic       nf;
        ss_low(mo_bytes[0][7]);
        for (int b = 0; b < n; b++) begin
            nf = (b + 1 < n) ? mo_bytes[b + 1][7] : 1'b0;
            xfer_byte(mo_bytes[b], nf, mi);
            mi_bytes[b] = mi;
        end
        ss_high();
    endtask

    initial begin
        int   rx0, und0, ovr0, abt0;
        logic dummy;
        aresetn       = 1'b0;
        SCK_I         = 1'b0;
        SS_I          = 1'b1;
        IO0_I         = 1'b0;
        IO1_I         = 1'b0;
        m_axis_tready = 1'b1;
        tick(3);

        check("rst_io1_t", IO1_T, 1);
        check("rst_io1_o", IO1_O, 0);
        check("rst_s_tready", s_axis_tready, 0);
        check("rst_m_tvalid", m_axis_tvalid, 0);
        check("rst_m_tdata", m_axis_tdata, 8'h00);
        check("rst_pulses", {rx_overrun, tx_underrun, frame_abort}, 0);
        aresetn = 1'b1;
        tick(1);
        check("post_rst_s_tready", s_axis_tready, 1);

        // Single byte; a trailing filler byte covers the preload at the 8th fall.
        rx0 = rx_n; und0 = und_cnt;
        push_tx(8'h3C);
        push_tx(8'h00);
        tick(4);
        mo_bytes[0] = 8'hA5;
        run_frame(1);
        check("t1_rx_beats", rx_n - rx0, 1);
        check("t1_rx_data", rx_log[rx0], 8'hA5);
        check("t1_miso", mi_bytes[0], 8'h3C);
        check("t1_underrun", und_cnt - und0, 0);

        rx0 = rx_n; und0 = und_cnt; ovr0 = ovr_cnt; abt0 = abt_cnt;
        push_tx(8'h10);
        push_tx(8'h20);
        push_tx(8'h30);
        push_tx(8'h40);
        tick(4);
        mo_bytes[0] = 8'h01; mo_bytes[1] = 8'h02; mo_bytes[2] = 8'h03;
        run_frame(3);
        check("t2_rx_beats", rx_n - rx0, 3);
        check("t2_rx0", rx_log[rx0], 8'h01);
        check("t2_rx1", rx_log[rx0 + 1], 8'h02);
        check("t2_rx2", rx_log[rx0 + 2], 8'h03);
        check("t2_miso0", mi_bytes[0], 8'h10);
        check("t2_miso1", mi_bytes[1], 8'h20);
        check("t2_miso2", mi_bytes[2], 8'h30);
        check("t2_pulses", (und_cnt - und0) + (ovr_cnt - ovr0) + (abt_cnt - abt0), 0);

        // Empty TX: fill byte at frame start and after each of the two bytes.
        und0 = und_cnt;
        tick(2);
        watch_tready = 1'b1;
        mo_bytes[0] = 8'h00; mo_bytes[1] = 8'h00;
        run_frame(2);
        watch_tready = 1'b0;
        check("t3_miso0", mi_bytes[0], 8'hFF);
        check("t3_miso1", mi_bytes[1], 8'hFF);
        check("t3_underrun", und_cnt - und0, 3);
        check("t3_tready_low", tready_low_cnt, 0);

        rx0 = rx_n; ovr0 = ovr_cnt;
        m_axis_tready = 1'b0;
        mo_bytes[0] = 8'h11; mo_bytes[1] = 8'h22;
        run_frame(2);
        check("t4_hold_data", m_axis_tdata, 8'h11);
        check("t4_hold_valid", m_axis_tvalid, 1);
        check("t4_overrun", ovr_cnt - ovr0, 1);
        check("t4_no_beat", rx_n - rx0, 0);
        m_axis_tready = 1'b1;
        tick(3);
        check("t4_beats", rx_n - rx0, 1);
        check("t4_beat_data", rx_log[rx0], 8'h11);
        check("t4_valid_clr", m_axis_tvalid, 0);

        rx0 = rx_n; abt0 = abt_cnt;
        ss_low(1'b1);
        for (int i = 0; i < 5; i++) sck_bit(1'b1, dummy);
        ss_high();
        check("t5_abort", abt_cnt - abt0, 1);
        check("t5_io1_t_idle", IO1_T, 1);
        check("t5_no_beat", rx_n - rx0, 0);
        mo_bytes[0] = 8'h5A;
        run_frame(1);
        check("t5_rx_beats", rx_n - rx0, 1);
        check("t5_rx_data", rx_log[rx0], 8'h5A);
        check("t5_abort_once", abt_cnt - abt0, 1);

        // Reset lands mid-byte while MISO is driving a 1 and m_axis_tdata holds 5A.
        ss_low(1'b1);
        for (int i = 0; i < 3; i++) sck_bit(1'b1, dummy);
        check("t6_pre_io1_o", IO1_O, 1);
        aresetn = 1'b0;
        SS_I    = 1'b1;
        tick(1);
        check("t6_rst_io1_t", IO1_T, 1);
        check("t6_rst_io1_o", IO1_O, 0);
        check("t6_rst_s_tready", s_axis_tready, 0);
        check("t6_rst_m_tvalid", m_axis_tvalid, 0);
        check("t6_rst_m_tdata", m_axis_tdata, 8'h00);
        tick(1);
        aresetn = 1'b1;
        tick(8);
        rx0 = rx_n; abt0 = abt_cnt;
        mo_bytes[0] = 8'hC3;
        run_frame(1);
        check("t6_rx_beats", rx_n - rx0, 1);
        check("t6_rx_data", rx_log[rx0], 8'hC3);
        check("t6_no_abort", abt_cnt - abt0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
